mcpu_mem_scratch_resp: RTL

//  Responder end of the 256-bit cache-line request interface (valid/stall/opcode/addr/wdata/wbe ->

---
 rtl/mcpu_mem_pkg.sv | 34 +++
 rtl/mcpu_mem_resp_delay.sv | 35 +++
 rtl/mcpu_mem_scratch_resp.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared opcodes, line geometry, FSM state type and byte-merge helper for the scratch-RAM responder.
package mcpu_mem_pkg;

  localparam int LINE_BITS    = 256;
  localparam int LINE_BE_BITS = 32;

  // Galois right-shift feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    OPC_READ    = 3'b000,
    OPC_WRITE   = 3'b001,
    OPC_RMW_NOP = 3'b111
  } mcpu_mem_opc_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

  function automatic logic [LINE_BITS-1:0] be_merge(
    input logic [LINE_BITS-1:0]    old_line,
    input logic [LINE_BITS-1:0]    new_line,
    input logic [LINE_BE_BITS-1:0] be
  );
    logic [LINE_BITS-1:0] merged;
    merged = old_line;
    for (int unsigned i = 0; i < LINE_BE_BITS; i++) begin
      if (be[i]) merged[8*i +: 8] = new_line[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mcpu_mem_resp_delay.sv
// Fixed-latency valid/data shift pipe; flushed by reset, output data holds the last valid entry.
module mcpu_mem_resp_delay #(
  parameter int WIDTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  // Data stages only move with a valid entry so the last stage never shows bubble contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld_i;
      if (in_vld_i) data_q[0] <= in_data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld_o  = vld_q[LATENCY-1];
  assign out_data_o = data_q[LATENCY-1];

endmodule

// File: rtl/mcpu_mem_scratch_resp.sv
// Scratch-RAM responder for the 256-bit line request interface: fixed latency, busy back-pressure.
// Optional random stall injection enabled by defining MCPU_MEM_RESP_RANDSTALL_EN.
module mcpu_mem_scratch_resp
  import mcpu_mem_pkg::*;
#(
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 2,
  parameter int BUSY_CYC   = 0
) (
  input  logic                    clkrst_mem_clk,
  input  logic                    clkrst_mem_rst,
  input  logic                    arb2ltc_valid,
  input  logic [2:0]              arb2ltc_opcode,
  input  logic [26:0]             arb2ltc_addr,
  input  logic [LINE_BITS-1:0]    arb2ltc_wdata,
  input  logic [LINE_BE_BITS-1:0] arb2ltc_wbe,
  output logic                    arb2ltc_stall,
  output logic [LINE_BITS-1:0]    arb2ltc_rdata,
  output logic                    arb2ltc_rvalid
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

  logic [LINE_BITS-1:0]  ram_q [DEPTH];
  logic                  accept;
  logic [DEPTH_BITS-1:0] idx;
  logic [LINE_BITS-1:0]  rd_line;
  logic [LINE_BITS-1:0]  resp_line;
  logic                  rand_stall;

  busy_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q, stall_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^arb2ltc_addr[26:DEPTH_BITS];

  assign accept  = arb2ltc_valid && !stall_q && !clkrst_mem_rst;
  assign idx     = arb2ltc_addr[DEPTH_BITS-1:0];
  assign rd_line = ram_q[idx];

  always_comb begin
    resp_line = '0;
    if (arb2ltc_opcode == OPC_READ) begin
      resp_line = rd_line;
    end else if (arb2ltc_opcode == OPC_WRITE) begin
      resp_line = be_merge(rd_line, arb2ltc_wdata, arb2ltc_wbe);
    end
  end

  // RAM has no reset; the merged line doubles as the write-ack payload.
  always_ff @(posedge clkrst_mem_clk) begin
    if (accept && (arb2ltc_opcode == OPC_WRITE)) ram_q[idx] <= resp_line;
  end

`ifdef MCPU_MEM_RESP_RANDSTALL_EN
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) lfsr_q <= 32'h1;
    else                lfsr_q <= lfsr_d;
  end

  assign rand_stall = (lfsr_d[1:0] == 2'b00);
`else
  assign rand_stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && (BUSY_CYC > 0)) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(BUSY_CYC - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Stall is registered, so it is derived from the state being entered.
    stall_d = (state_d == ST_BUSY) || ((state_d == ST_IDLE) && rand_stall);
  end

  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign arb2ltc_stall = stall_q;

  mcpu_mem_resp_delay #(
    .WIDTH   (LINE_BITS),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk_i      (clkrst_mem_clk),
    .rst_i      (clkrst_mem_rst),
    .in_vld_i   (accept),
    .in_data_i  (resp_line),
    .out_vld_o  (arb2ltc_rvalid),
    .out_data_o (arb2ltc_rdata)
  );

endmodule
